// File: rtl/fifo_write_ctrl_if.sv
// rtl/fifo_write_ctrl_if.sv - producer/read-pointer bundle for the FIFO write-side controller
interface fifo_write_ctrl_if #(
  parameter int ADDR_W = 4
) ();
  logic              wr_en_i;
  logic              ovf_clr_i;
  logic [ADDR_W:0]   rd_ptr_gray_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_ptr_to_mem;
  logic [ADDR_W:0]   wr_ptr_to_rd_ctrl;
  logic [ADDR_W:0]   wr_ptr_gray_o;
  logic              fifo_full_o;
  logic              fifo_afull_o;
  logic [ADDR_W:0]   wr_level_o;
  logic              overflow_o;

  modport slave (
    input  wr_en_i, ovf_clr_i, rd_ptr_gray_i,
    output wr_en_o, wr_ptr_to_mem, wr_ptr_to_rd_ctrl, wr_ptr_gray_o,
           fifo_full_o, fifo_afull_o, wr_level_o, overflow_o
  );

  modport master (
    output wr_en_i, ovf_clr_i, rd_ptr_gray_i,
    input  wr_en_o, wr_ptr_to_mem, wr_ptr_to_rd_ctrl, wr_ptr_gray_o,
           fifo_full_o, fifo_afull_o, wr_level_o, overflow_o
  );
endinterface

// File: rtl/fifo_write_ctrl.sv
// rtl/fifo_write_ctrl.sv - async FIFO write pointer, Gray export and conservative full/level flags
module fifo_write_ctrl #(
  parameter int ADDR_W       = 4,
  parameter int AFULL_THRESH = 12,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             clk_i,
  input  logic             rst_n,
  fifo_write_ctrl_if.slave bus
);
  localparam logic [ADDR_W:0] AFULL_V = (ADDR_W + 1)'(AFULL_THRESH);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

  logic [ADDR_W:0] sync_q [SYNC_STAGES];
  logic [ADDR_W:0] rq;
  logic [ADDR_W:0] rd_bin;
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] wr_ptr_gray;
  logic [ADDR_W:0] wr_ptr_nxt;
  logic [ADDR_W:0] level;
  logic            full;
  logic            wr_ok;
  logic            ovf;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.rd_ptr_gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rq = sync_q[SYNC_STAGES-1];

  // Bit i of the binary value is the XOR of all Gray bits at or above i.
  always_comb begin
    rd_bin = '0;
    for (int i = 0; i <= ADDR_W; i++) rd_bin[i] = ^(rq >> i);
  end

  assign full  = (wr_ptr[ADDR_W] != rd_bin[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_bin[ADDR_W-1:0]);
  assign level = wr_ptr - rd_bin;
  // Held off during reset so no write strobe reaches memory while state is clearing.
  assign wr_ok = bus.wr_en_i && !full && rst_n;
  assign wr_ptr_nxt = wr_ptr + PTR_ONE;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      wr_ptr_gray <= '0;
    end else if (wr_ok) begin
      wr_ptr      <= wr_ptr_nxt;
      wr_ptr_gray <= wr_ptr_nxt ^ (wr_ptr_nxt >> 1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (bus.wr_en_i && full) begin
      ovf <= 1'b1;
    end else if (bus.ovf_clr_i) begin
      ovf <= 1'b0;
    end
  end

  assign bus.wr_en_o           = wr_ok;
  assign bus.wr_ptr_to_mem     = wr_ptr[ADDR_W-1:0];
  assign bus.wr_ptr_to_rd_ctrl = wr_ptr;
  assign bus.wr_ptr_gray_o     = wr_ptr_gray;
  assign bus.fifo_full_o       = full;
  assign bus.fifo_afull_o      = (level >= AFULL_V);
  assign bus.wr_level_o        = level;
  assign bus.overflow_o        = ovf;
endmodule

// File: tb/tb_fifo_write_ctrl.sv
// tb/tb_fifo_write_ctrl.sv - scoreboard bench for fifo_write_ctrl
module tb_fifo_write_ctrl;
  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rg = 5'd0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    string      name;
    logic       we;
    logic [3:0] addr;
    logic [4:0] ptr;
    logic [4:0] gray;
    logic       full;
    logic       afull;
    logic [4:0] lvl;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];

  fifo_write_ctrl_if #(.ADDR_W(4)) bus ();

  fifo_write_ctrl #(.ADDR_W(4), .AFULL_THRESH(12), .SYNC_STAGES(2)) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s.%s actual=%0h required=%0h at %0t", nm, fld, act, expv, $time);
    end
  endtask

  // Monitor: mid-cycle, compares DUT outputs with the oldest queued expectation.
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "wr_en_o",  32'(bus.wr_en_o),           32'(e.we));
      chk(e.name, "mem_addr", 32'(bus.wr_ptr_to_mem),     32'(e.addr));
      chk(e.name, "wr_ptr",   32'(bus.wr_ptr_to_rd_ctrl), 32'(e.ptr));
      chk(e.name, "gray",     32'(bus.wr_ptr_gray_o),     32'(e.gray));
      chk(e.name, "full",     32'(bus.fifo_full_o),       32'(e.full));
      chk(e.name, "afull",    32'(bus.fifo_afull_o),      32'(e.afull));
      chk(e.name, "level",    32'(bus.wr_level_o),        32'(e.lvl));
      chk(e.name, "ovf",      32'(bus.overflow_o),        32'(e.ovf));
    end
  end

  // Drives one cycle of inputs (called at posedge+1) and queues the outputs expected mid-cycle.
  task automatic apply(input logic we, input logic clr, input string nm, input logic e_we,
                       input int e_ptr, input logic e_full, input int e_lvl, input logic e_ovf);
    exp_t e;
    bus.wr_en_i       = we;
    bus.ovf_clr_i     = clr;
    bus.rd_ptr_gray_i = rg;
    e.name  = nm;
    e.we    = e_we;
    e.ptr   = 5'(e_ptr);
    e.addr  = e.ptr[3:0];
    e.gray  = e.ptr ^ (e.ptr >> 1);
    e.full  = e_full;
    e.lvl   = 5'(e_lvl);
    e.afull = (e_lvl >= 12);
    e.ovf   = e_ovf;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    bus.wr_en_i       = 1'b0;
    bus.ovf_clr_i     = 1'b0;
    bus.rd_ptr_gray_i = 5'd0;
    @(posedge clk_i);
    #1;

    apply(1, 0, "rst_hold", 0, 0, 0, 0, 0);
    apply(0, 0, "rst_hold", 0, 0, 0, 0, 0);
    apply(1, 0, "rst_hold", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) apply(0, 0, "rst_idle", 0, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) apply(1, 0, "fill", 1, i, 0, i, 0);
    apply(0, 0, "full", 0, 16, 1, 16, 0);

    apply(1, 0, "ovf_try",     0, 16, 1, 16, 0);
    apply(1, 1, "ovf_set_clr", 0, 16, 1, 16, 1);
    apply(0, 1, "ovf_clr",     0, 16, 1, 16, 1);
    apply(0, 0, "ovf_cleared", 0, 16, 1, 16, 0);

    rg = 5'b00110;
    apply(0, 0, "rel_e0", 0, 16, 1, 16, 0);
    apply(0, 0, "rel_e1", 0, 16, 1, 16, 0);
    apply(0, 0, "rel_e2", 0, 16, 0, 12, 0);

    rg = 5'b11000;
    apply(0, 0, "wrap_sync0", 0, 16, 0, 12, 0);
    apply(0, 0, "wrap_sync1", 0, 16, 0, 12, 0);
    apply(0, 0, "wrap_sync2", 0, 16, 0, 0, 0);
    for (int i = 0; i < 16; i++) apply(1, 0, "wrap_wr", 1, 16 + i, 0, i, 0);
    apply(0, 0, "wrap_full", 0, 0, 1, 16, 0);

    rg = 5'b00000;
    apply(0, 0, "rd0_s0", 0, 0, 1, 16, 0);
    apply(0, 0, "rd0_s1", 0, 0, 1, 16, 0);
    apply(0, 0, "rd0_s2", 0, 0, 0, 0, 0);

    rg = 5'b00001;
    for (int k = 0; k < 8; k++) apply(1, 0, "lvl_wr", 1, k, 0, (k < 2) ? k : k - 1, 0);

    // Mid-cycle reset at level 7 with a write pending: queued check covers the pre-reset view.
    bus.wr_en_i = 1'b1;
    begin
      exp_t e;
      e.name = "pre_rst"; e.we = 1; e.ptr = 5'd8; e.addr = 4'd8; e.gray = 5'b01100;
      e.full = 0; e.afull = 0; e.lvl = 5'd7; e.ovf = 0;
      exp_q.push_back(e);
    end
    #6;
    rst_n = 1'b0;
    #1;
    chk("mid_rst", "wr_ptr",  32'(bus.wr_ptr_to_rd_ctrl), 32'd0);
    chk("mid_rst", "gray",    32'(bus.wr_ptr_gray_o),     32'd0);
    chk("mid_rst", "level",   32'(bus.wr_level_o),        32'd0);
    chk("mid_rst", "wr_en_o", 32'(bus.wr_en_o),           32'd0);
    chk("mid_rst", "full",    32'(bus.fifo_full_o),       32'd0);
    @(posedge clk_i);
    #1;
    rg = 5'b00000;
    apply(1, 0, "in_rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    apply(0, 0, "post_rst0", 0, 0, 0, 0, 0);
    apply(0, 0, "post_rst1", 0, 0, 0, 0, 0);
    apply(1, 0, "post_wr",   1, 0, 0, 0, 0);
    apply(0, 0, "post_idle", 0, 1, 0, 1, 0);

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk_i);
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_write_ctrl.md
Name: fifo_write_ctrl

Overview:
- Write-side pointer and flag controller for the asynchronous FIFO; sits directly upstream of the read controller and the dual-port memory.
- Qualifies write requests against a full flag and advances the write pointer.
- Publishes the write pointer in binary form (read controller, memory address) and Gray form (cross-domain transfer).
- Synchronises the read domain's Gray pointer into the write clock to derive full, almost-full, level and overflow status.

Parameters:
- ADDR_W, 4, memory address width; depth = 2**ADDR_W; pointers are ADDR_W+1 bits.
- AFULL_THRESH, 12, level at or above which fifo_afull_o asserts; legal range 1..2**ADDR_W.
- SYNC_STAGES, 2, flop stages on the incoming read pointer; minimum 2.

Ports:
- clk_i  input  1  write-domain clock
- rst_n  input  1  asynchronous active-low reset
- wr_en_i  input  1  write request from producer
- ovf_clr_i  input  1  clears sticky overflow
- rd_ptr_gray_i  input  ADDR_W+1  Gray-coded read pointer from the read domain (unsynchronised)
- wr_en_o  output  1  qualified write strobe to memory
- wr_ptr_to_mem  output  ADDR_W  memory write address = wr_ptr[ADDR_W-1:0]
- wr_ptr_to_rd_ctrl  output  ADDR_W+1  binary write pointer
- wr_ptr_gray_o  output  ADDR_W+1  registered Gray write pointer
- fifo_full_o  output  1  FIFO full (write-side view)
- fifo_afull_o  output  1  almost full
- wr_level_o  output  ADDR_W+1  occupancy, write-side view
- overflow_o  output  1  sticky: write attempted while full

Behaviour:
- Reset (rst_n low, asynchronous, immediate):
  - wr_ptr, wr_ptr_gray, all sync flops and overflow clear to 0.
  - Hence fifo_full_o=0, fifo_afull_o=0 (AFULL_THRESH>=1), wr_level_o=0, wr_en_o=0.
  - Reset may assert mid-operation at any phase; no pending write completes.
- Synchroniser:
  - rd_ptr_gray_i passes through a SYNC_STAGES flop chain; rq = last stage.
  - A change on rd_ptr_gray_i is reflected in the flags exactly SYNC_STAGES rising edges later.
  - rd_bin = Gray-to-binary(rq), combinational.
- Full (combinational): fifo_full_o = (wr_ptr[ADDR_W] != rd_bin[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_bin[ADDR_W-1:0]).
- Level (combinational): wr_level_o = (wr_ptr - rd_bin) modulo 2**(ADDR_W+1); range 0..2**ADDR_W.
- Almost full (combinational): fifo_afull_o = (wr_level_o >= AFULL_THRESH).
- Write qualification: wr_en_o = wr_en_i && !fifo_full_o, same cycle, no latency.
- Pointer update on a rising edge with wr_en_o=1:
  - wr_ptr <= wr_ptr + 1, wrapping 2**(ADDR_W+1)-1 -> 0.
  - wr_ptr_gray <= bin2gray(wr_ptr + 1), same edge, so binary and Gray outputs always agree and the Gray output never glitches.
- Overflow:
  - An edge with wr_en_i=1 and fifo_full_o=1 sets overflow_o.
  - ovf_clr_i=1 clears it on the edge.
  - Set and clear on the same edge: set wins.
  - The rejected write has no effect on pointers or memory.
- Pessimism: flags are conservative only. Full/level may lag a read by SYNC_STAGES cycles; they never under-report occupancy. No false not-full is permitted.
- Simultaneous write and incoming read pointer change: the write uses the current (pre-update) rq; the level reflects both once the sync chain settles.

Test Plan:
- Reset check: hold rst_n=0, toggle clk_i and wr_en_i -> all outputs 0; release, idle 3 cycles -> still 0, fifo_full_o=0.
- Fill to full (ADDR_W=4, rd_ptr_gray_i=0):
  - 16 consecutive wr_en_i -> wr_en_o high for 16 cycles; wr_ptr_to_mem 0..15, then wr_ptr_to_rd_ctrl=5'b10000, wr_ptr_gray_o=5'b11000.
  - fifo_afull_o rises when level reaches 12.
  - fifo_full_o=1 and wr_level_o=16 after the 16th edge.
- Overflow:
  - While full, assert wr_en_i 1 cycle -> wr_en_o=0, pointer unchanged, overflow_o=1 next edge.
  - Pulse ovf_clr_i together with another full write -> stays 1.
  - Lone ovf_clr_i -> 0.
- Read release latency: while full, step rd_ptr_gray_i 0 -> 5'b00110 (binary 4) -> fifo_full_o stays 1 for exactly 2 edges, then 0 with wr_level_o=12 and fifo_afull_o=1.
- Pointer wrap:
  - With rd_bin near 16, write across wr_ptr 31 -> 0 -> wr_ptr_gray_o goes 5'b10000 -> 5'b00000.
  - With rq=5'b11000 (binary 16) and wr_ptr=0 -> fifo_full_o=1, wr_level_o=16.
- Mid-operation reset: at level 7 with wr_en_i high, drop rst_n between edges -> outputs clear before the next edge, sync chain cleared, no pointer increment on release.
